parity_frame_checker: RTL

- Parametrised successor to the single-bit parity FSM: checks parity over multi-beat frames of DATA_W-bit words.
- Supports selectable even/odd mode, latched per frame, and a maximum frame length with overflow detection.
- Provides a Mealy-style check result on the last beat, a registered copy one cycle later, and saturating good/bad frame counters.
- Sits on a receive datapath, after a deserialiser and before frame-accept logic.

---
 rtl/parity_frame_checker_if.sv | 13 +
 rtl/parity_frame_checker.sv | 135 +++++++++++++
 2 files changed

// File: rtl/parity_frame_checker_if.sv
// Beat bus feeding the parity frame checker: one qualified word per cycle.
// No latency of its own; pure wiring bundle.
// No backpressure: the receiver consumes every beat with in_valid=1.
interface parity_frame_checker_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_last;

   modport master (output in_valid, output in_data, output in_last);
   modport slave  (input  in_valid, input  in_data, input  in_last);
endinterface

// File: rtl/parity_frame_checker.sv
// Checks even/odd parity over multi-beat frames, flags overlong frames, and counts good/bad frames.
// chk_* is combinational on the last beat; res_* follows one cycle later; counters update on that same edge.
// No backpressure: every valid beat is consumed; overlong frames are drained until their last beat.
module parity_frame_checker #(
   parameter int DATA_W    = 8,
   parameter int MAX_BEATS = 16,
   parameter int CNT_W     = 16,
   localparam int BEAT_W   = $clog2(MAX_BEATS + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     odd_mode,
   parity_frame_checker_if.slave    beat,
   output logic                     chk_valid,
   output logic                     chk_ok,
   output logic                     res_valid,
   output logic                     res_ok,
   output logic                     res_ovf,
   output logic [BEAT_W-1:0]        beat_cnt,
   output logic [CNT_W-1:0]         good_cnt,
   output logic [CNT_W-1:0]         bad_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [BEAT_W-1:0] MAX_BEATS_C = BEAT_W'(MAX_BEATS);

   state_t              state;
   logic                acc;      // running parity of the beats seen so far
   logic                mode_q;   // parity mode latched on the frame's first beat
   logic [DATA_W-1:0]   data;
   logic                p;
   logic                frame_end;
   logic [BEAT_W-1:0]   beat_cnt_inc;

   // Overflow is carried by the DRAIN state itself: a frame ending from
   // DRAIN is by definition the overlong one, so no separate flag is kept.
   assign data         = beat.in_data;
   assign beat_cnt_inc = beat_cnt + BEAT_W'(1);

   // Mealy check result: only a valid last beat that is not being cleared ends a frame.
   always_comb begin
      p         = ^data;
      frame_end = beat.in_valid & beat.in_last & ~clr;
      chk_valid = frame_end;
      chk_ok    = 1'b0;
      if (frame_end) begin
         case (state)
            IDLE:    chk_ok = (p == odd_mode);
            ACCUM:   chk_ok = ((acc ^ p) == mode_q);
            default: chk_ok = 1'b0;
         endcase
      end
   end

   // Frame FSM, registered results and saturating counters; clr outranks everything but reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= 1'b0;
         mode_q    <= 1'b0;
         beat_cnt  <= '0;
         res_valid <= 1'b0;
         res_ok    <= 1'b0;
         res_ovf   <= 1'b0;
         good_cnt  <= '0;
         bad_cnt   <= '0;
      end else if (clr) begin
         state     <= IDLE;
         acc       <= 1'b0;
         beat_cnt  <= '0;
         res_valid <= 1'b0;
         res_ok    <= 1'b0;
         res_ovf   <= 1'b0;
         good_cnt  <= '0;
         bad_cnt   <= '0;
      end else begin
         res_valid <= frame_end;
         if (frame_end) begin
            res_ok  <= chk_ok;
            res_ovf <= (state == DRAIN);
            if (chk_ok) begin
               if (good_cnt != {CNT_W{1'b1}}) good_cnt <= good_cnt + CNT_W'(1);
            end else begin
               if (bad_cnt != {CNT_W{1'b1}})  bad_cnt  <= bad_cnt + CNT_W'(1);
            end
         end

         if (beat.in_valid) begin
            case (state)
               IDLE: begin
                  // A single-beat frame is fully resolved above and leaves IDLE untouched.
                  if (!beat.in_last) begin
                     acc      <= p;
                     mode_q   <= odd_mode;
                     beat_cnt <= BEAT_W'(1);
                     state    <= ACCUM;
                  end
               end
               ACCUM: begin
                  if (beat.in_last) begin
                     acc      <= 1'b0;
                     beat_cnt <= '0;
                     state    <= IDLE;
                  end else begin
                     acc      <= acc ^ p;
                     beat_cnt <= beat_cnt_inc;
                     // Beat MAX_BEATS arriving without last means the frame is overlong.
                     if (beat_cnt_inc == MAX_BEATS_C) state <= DRAIN;
                  end
               end
               DRAIN: begin
                  // Payload is ignored here; beat_cnt stays pinned at MAX_BEATS.
                  if (beat.in_last) begin
                     acc      <= 1'b0;
                     beat_cnt <= '0;
                     state    <= IDLE;
                  end
               end
               default: begin
                  state    <= IDLE;
                  acc      <= 1'b0;
                  beat_cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule
